// File: rtl/pe_multibank.sv
// Weight-stationary systolic PE with an N-deep ring of weight banks, row-matched loads and occupancy/error status.
// Optional macro PE_SAT_EN: saturating accumulation instead of two's-complement wrap.
module pe_multibank #(
  parameter int ROW_ID               = 0,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int NUM_WEIGHT_BANKS     = 2,
  localparam int INDEX_WIDTH         = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pe_enabled,
  input  logic                               pe_valid_in,
  input  logic                               pe_switch_in,
  input  logic                               pe_accept_w_in,
  input  logic signed [DATA_WIDTH_IN-1:0]    pe_weight_in,
  input  logic        [INDEX_WIDTH-1:0]      pe_index_in,
  input  logic signed [DATA_WIDTH_ACCUM-1:0] pe_psum_in,
  input  logic signed [DATA_WIDTH_IN-1:0]    pe_input_in,
  input  logic                               pe_err_clr,
  output logic signed [DATA_WIDTH_IN-1:0]    pe_weight_out,
  output logic        [INDEX_WIDTH-1:0]      pe_index_out,
  output logic                               pe_accept_w_out,
  output logic signed [DATA_WIDTH_IN-1:0]    pe_input_out,
  output logic                               pe_valid_out,
  output logic                               pe_switch_out,
  output logic signed [DATA_WIDTH_ACCUM-1:0] pe_psum_out,
  output logic                               pe_bank_full,
  output logic                               pe_bank_empty,
  output logic                               pe_weight_ovf,
  output logic                               pe_switch_err
);

  localparam int PTR_WIDTH  = $clog2(NUM_WEIGHT_BANKS);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH_IN;
  localparam logic [PTR_WIDTH-1:0]   LAST_SLOT = PTR_WIDTH'(NUM_WEIGHT_BANKS - 1);
  localparam logic [INDEX_WIDTH-1:0] ROW_IDX   = INDEX_WIDTH'(ROW_ID);

  logic signed [DATA_WIDTH_IN-1:0] weight_bank [NUM_WEIGHT_BANKS];
  logic [PTR_WIDTH-1:0] act_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] pend;

  logic load_hit;
  logic switch_ok;
  logic switch_bad;
  logic load_ok;
  logic load_drop;
  logic signed [DATA_WIDTH_IN-1:0]    active_weight;
  logic signed [PROD_WIDTH-1:0]       product;
  logic signed [DATA_WIDTH_ACCUM-1:0] product_ext;
  logic signed [DATA_WIDTH_ACCUM-1:0] mac_sum;

  function automatic logic [PTR_WIDTH-1:0] ring_next(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_SLOT) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  // A load into a full ring is still accepted when a same-cycle switch frees the slot being retired.
  assign load_hit   = pe_accept_w_in && (pe_index_in == ROW_IDX);
  assign switch_ok  = pe_switch_in && (pend != '0);
  assign switch_bad = pe_switch_in && (pend == '0);
  assign load_ok    = load_hit && ((pend != LAST_SLOT) || switch_ok);
  assign load_drop  = load_hit && !load_ok;

  assign active_weight = weight_bank[act_ptr];
  assign product       = pe_input_in * active_weight;
  assign product_ext   = DATA_WIDTH_ACCUM'(product);

`ifdef PE_SAT_EN
  localparam logic signed [DATA_WIDTH_ACCUM-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH_ACCUM-1){1'b1}}};
  localparam logic signed [DATA_WIDTH_ACCUM-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH_ACCUM-1){1'b0}}};
  logic [DATA_WIDTH_ACCUM:0] wide_sum;

  assign wide_sum = {pe_psum_in[DATA_WIDTH_ACCUM-1], pe_psum_in}
                  + {product_ext[DATA_WIDTH_ACCUM-1], product_ext};

  // The two top bits of the widened sum disagree exactly when the narrow sum overflowed.
  always_comb begin
    mac_sum = wide_sum[DATA_WIDTH_ACCUM-1:0];
    if (wide_sum[DATA_WIDTH_ACCUM] != wide_sum[DATA_WIDTH_ACCUM-1]) begin
      mac_sum = wide_sum[DATA_WIDTH_ACCUM] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign mac_sum = pe_psum_in + product_ext;
`endif

  assign pe_bank_empty = (pend == '0);
  assign pe_bank_full  = (pend == LAST_SLOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_weight_out   <= '0;
      pe_index_out    <= '0;
      pe_accept_w_out <= 1'b0;
      pe_input_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_switch_out   <= 1'b0;
      pe_psum_out     <= '0;
    end else if (!pe_enabled) begin
      pe_weight_out   <= '0;
      pe_index_out    <= '0;
      pe_accept_w_out <= 1'b0;
      pe_input_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_switch_out   <= 1'b0;
      pe_psum_out     <= pe_psum_in;
    end else begin
      pe_weight_out   <= pe_weight_in;
      pe_index_out    <= pe_index_in;
      pe_accept_w_out <= pe_accept_w_in && (pe_index_in != ROW_IDX);
      pe_input_out    <= pe_input_in;
      pe_valid_out    <= pe_valid_in;
      pe_switch_out   <= pe_switch_in;
      pe_psum_out     <= pe_valid_in ? mac_sum : pe_psum_in;
    end
  end

  // Ring control: the active bank is read before this edge, so a same-cycle load never becomes active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WEIGHT_BANKS; i++) begin
        weight_bank[i] <= '0;
      end
      act_ptr       <= '0;
      wr_ptr        <= PTR_WIDTH'(1);
      pend          <= '0;
      pe_weight_ovf <= 1'b0;
      pe_switch_err <= 1'b0;
    end else if (pe_enabled) begin
      if (load_ok) begin
        weight_bank[wr_ptr] <= pe_weight_in;
        wr_ptr              <= ring_next(wr_ptr);
      end
      if (switch_ok) begin
        act_ptr <= ring_next(act_ptr);
      end
      if (load_ok && !switch_ok) begin
        pend <= pend + PTR_WIDTH'(1);
      end else if (switch_ok && !load_ok) begin
        pend <= pend - PTR_WIDTH'(1);
      end
      if (load_drop) begin
        pe_weight_ovf <= 1'b1;
      end else if (pe_err_clr) begin
        pe_weight_ovf <= 1'b0;
      end
      if (switch_bad) begin
        pe_switch_err <= 1'b1;
      end else if (pe_err_clr) begin
        pe_switch_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_multibank.sv
// Directed table-driven bench for pe_multibank (ROW_ID=5, three banks, 8/32-bit widths),
// plus a hand-written asynchronous reset sequence.
module tb_pe_multibank;

  logic               clk;
  logic               rst_n;
  logic               pe_enabled;
  logic               pe_valid_in;
  logic               pe_switch_in;
  logic               pe_accept_w_in;
  logic signed [7:0]  pe_weight_in;
  logic [3:0]         pe_index_in;
  logic signed [31:0] pe_psum_in;
  logic signed [7:0]  pe_input_in;
  logic               pe_err_clr;
  logic signed [7:0]  pe_weight_out;
  logic [3:0]         pe_index_out;
  logic               pe_accept_w_out;
  logic signed [7:0]  pe_input_out;
  logic               pe_valid_out;
  logic               pe_switch_out;
  logic signed [31:0] pe_psum_out;
  logic               pe_bank_full;
  logic               pe_bank_empty;
  logic               pe_weight_ovf;
  logic               pe_switch_err;

  int checks_total;
  int checks_passed;

  pe_multibank #(
    .ROW_ID(5),
    .SYSTOLIC_ARRAY_WIDTH(16),
    .DATA_WIDTH_IN(8),
    .DATA_WIDTH_ACCUM(32),
    .NUM_WEIGHT_BANKS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pe_enabled(pe_enabled),
    .pe_valid_in(pe_valid_in),
    .pe_switch_in(pe_switch_in),
    .pe_accept_w_in(pe_accept_w_in),
    .pe_weight_in(pe_weight_in),
    .pe_index_in(pe_index_in),
    .pe_psum_in(pe_psum_in),
    .pe_input_in(pe_input_in),
    .pe_err_clr(pe_err_clr),
    .pe_weight_out(pe_weight_out),
    .pe_index_out(pe_index_out),
    .pe_accept_w_out(pe_accept_w_out),
    .pe_input_out(pe_input_out),
    .pe_valid_out(pe_valid_out),
    .pe_switch_out(pe_switch_out),
    .pe_psum_out(pe_psum_out),
    .pe_bank_full(pe_bank_full),
    .pe_bank_empty(pe_bank_empty),
    .pe_weight_ovf(pe_weight_ovf),
    .pe_switch_err(pe_switch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        val;
    logic        sw;
    logic        acc;
    logic        clr;
    logic [7:0]  w;
    logic [3:0]  idx;
    logic [31:0] psum;
    logic [7:0]  inp;
    logic [31:0] e_psum;
    logic        e_acc;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic        e_serr;
  } vec_t;

  localparam int NUM_VECS = 22;
  vec_t vecs [NUM_VECS];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pe_enabled     = v.en;
    pe_valid_in    = v.val;
    pe_switch_in   = v.sw;
    pe_accept_w_in = v.acc;
    pe_err_clr     = v.clr;
    pe_weight_in   = v.w;
    pe_index_in    = v.idx;
    pe_psum_in     = v.psum;
    pe_input_in    = v.inp;
  endtask

  task automatic idleInputs();
    pe_enabled     = 1'b1;
    pe_valid_in    = 1'b0;
    pe_switch_in   = 1'b0;
    pe_accept_w_in = 1'b0;
    pe_err_clr     = 1'b0;
    pe_weight_in   = '0;
    pe_index_in    = '0;
    pe_psum_in     = '0;
    pe_input_in    = '0;
  endtask

  logic [31:0] sat_expect;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
`ifdef PE_SAT_EN
    sat_expect = 32'h7FFF_FFFF;
`else
    sat_expect = 32'h8000_3F00;
`endif

    // Fields: en val sw acc clr w idx psum inp | e_psum e_acc e_full e_empty e_ovf e_serr
    vecs[0]  = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'd1000, 8'd10,  32'd1000, 0, 0, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 1, 0, 8'hAA, 4'd6, 32'd55,   8'd0,   32'd55,   1, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 1, 0, 8'd10, 4'd5, 32'd0,    8'd0,   32'd0,    0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 1, 0, 8'd20, 4'd5, 32'd0,    8'd0,   32'd0,    0, 1, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 1, 0, 8'd30, 4'd5, 32'd0,    8'd0,   32'd0,    0, 1, 0, 1, 0};
    vecs[5]  = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'd100,  8'd7,   32'd100,  0, 1, 0, 1, 0};
    vecs[6]  = '{1, 0, 1, 0, 0, 8'h00, 4'd0, 32'd0,    8'd0,   32'd0,    0, 0, 0, 1, 0};
    vecs[7]  = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'd100,  8'd7,   32'd170,  0, 0, 0, 1, 0};
    vecs[8]  = '{1, 0, 1, 0, 0, 8'h00, 4'd0, 32'd0,    8'd0,   32'd0,    0, 0, 1, 1, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'd170,  8'hFE,  32'd130,  0, 0, 1, 1, 0};
    vecs[10] = '{1, 0, 1, 0, 0, 8'h00, 4'd0, 32'd0,    8'd0,   32'd0,    0, 0, 1, 1, 1};
    vecs[11] = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'd0,    8'd3,   32'd60,   0, 0, 1, 1, 1};
    vecs[12] = '{1, 0, 0, 0, 1, 8'h00, 4'd0, 32'd0,    8'd0,   32'd0,    0, 0, 1, 0, 0};
    vecs[13] = '{1, 0, 0, 1, 0, 8'd127, 4'd5, 32'd0,   8'd0,   32'd0,    0, 0, 0, 0, 0};
    vecs[14] = '{1, 0, 0, 1, 0, 8'd50, 4'd5, 32'd0,    8'd0,   32'd0,    0, 1, 0, 0, 0};
    vecs[15] = '{1, 0, 1, 1, 0, 8'hFD, 4'd5, 32'd0,    8'd0,   32'd0,    0, 1, 0, 0, 0};
    vecs[16] = '{0, 1, 1, 1, 0, 8'd9,  4'd5, 32'd12345, 8'd4,  32'd12345, 0, 1, 0, 0, 0};
    vecs[17] = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'h7FFF_FFFF, 8'd127, sat_expect, 0, 1, 0, 0, 0};
    vecs[18] = '{1, 0, 1, 0, 0, 8'h00, 4'd0, 32'd0,    8'd0,   32'd0,    0, 0, 0, 0, 0};
    vecs[19] = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'd0,    8'd2,   32'd100,  0, 0, 0, 0, 0};
    vecs[20] = '{1, 0, 1, 0, 0, 8'h00, 4'd0, 32'd0,    8'd0,   32'd0,    0, 0, 1, 0, 0};
    vecs[21] = '{1, 1, 0, 0, 0, 8'h00, 4'd0, 32'd0,    8'd4,   32'hFFFF_FFF4, 0, 0, 1, 0, 0};

    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-cycle after a MAC must clear outputs without waiting for an edge.
    @(negedge clk);
    pe_valid_in = 1'b1;
    pe_input_in = 8'd5;
    pe_psum_in  = 32'd77;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_psum", pe_psum_out, 32'd77);
    checkOutput("pre_reset_valid", {31'd0, pe_valid_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_psum", pe_psum_out, 32'd0);
    checkOutput("async_reset_valid", {31'd0, pe_valid_out}, 32'd0);
    checkOutput("async_reset_input", {24'd0, pe_input_out}, 32'd0);
    checkOutput("async_reset_empty", {31'd0, pe_bank_empty}, 32'd1);
    checkOutput("async_reset_full", {31'd0, pe_bank_full}, 32'd0);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Each vector occupies one cycle; pass-through expectations follow the enable.
    for (int i = 0; i < NUM_VECS; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_psum", i), pe_psum_out, vecs[i].e_psum);
      checkOutput($sformatf("v%0d_accept", i), {31'd0, pe_accept_w_out}, {31'd0, vecs[i].e_acc});
      checkOutput($sformatf("v%0d_full", i), {31'd0, pe_bank_full}, {31'd0, vecs[i].e_full});
      checkOutput($sformatf("v%0d_empty", i), {31'd0, pe_bank_empty}, {31'd0, vecs[i].e_empty});
      checkOutput($sformatf("v%0d_ovf", i), {31'd0, pe_weight_ovf}, {31'd0, vecs[i].e_ovf});
      checkOutput($sformatf("v%0d_serr", i), {31'd0, pe_switch_err}, {31'd0, vecs[i].e_serr});
      checkOutput($sformatf("v%0d_weight", i), {24'd0, pe_weight_out}, vecs[i].en ? {24'd0, vecs[i].w} : 32'd0);
      checkOutput($sformatf("v%0d_index", i), {28'd0, pe_index_out}, vecs[i].en ? {28'd0, vecs[i].idx} : 32'd0);
      checkOutput($sformatf("v%0d_input", i), {24'd0, pe_input_out}, vecs[i].en ? {24'd0, vecs[i].inp} : 32'd0);
      checkOutput($sformatf("v%0d_valid", i), {31'd0, pe_valid_out}, {31'd0, vecs[i].en & vecs[i].val});
      checkOutput($sformatf("v%0d_switch", i), {31'd0, pe_switch_out}, {31'd0, vecs[i].en & vecs[i].sw});
    end

    @(negedge clk);
    idleInputs();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pe_multibank.md
Name: pe_multibank

Overview:
- Next-generation weight-stationary systolic-array processing element with a parametrised N-deep ring of weight banks, replacing the fixed active/inactive pair.
- Weights are loaded by row-index match, which consumes the accept strobe.
- Switch pulses advance the active bank. Occupancy tracking provides full/empty status and sticky error flags.
- Sits in the systolic array mesh: weights, index and accept propagate vertically; input, valid and switch propagate horizontally; psum propagates vertically.

Parameters:
- ROW_ID, 0, row this PE matches for weight loads
- SYSTOLIC_ARRAY_WIDTH, 16, array dimension; INDEX_WIDTH = $clog2(SYSTOLIC_ARRAY_WIDTH) (localparam)
- DATA_WIDTH_IN, 8, signed input/weight width
- DATA_WIDTH_ACCUM, 32, signed psum width; must be >= 2*DATA_WIDTH_IN
- NUM_WEIGHT_BANKS, 2, weight ring depth; must be >= 2

Ports:
- clk in 1 clock
- rst_n in 1 asynchronous reset, active-low
- pe_enabled in 1 PE enable
- pe_valid_in in 1 input valid
- pe_switch_in in 1 advance active bank
- pe_accept_w_in in 1 weight-load strobe
- pe_weight_in in DATA_WIDTH_IN signed load weight
- pe_index_in in INDEX_WIDTH target row of load
- pe_psum_in in DATA_WIDTH_ACCUM signed psum from above
- pe_input_in in DATA_WIDTH_IN signed activation from left
- pe_err_clr in 1 synchronous clear of sticky errors
- pe_weight_out, pe_index_out, pe_accept_w_out out: registered vertical pass-through
- pe_input_out, pe_valid_out, pe_switch_out out: registered horizontal pass-through
- pe_psum_out out DATA_WIDTH_ACCUM signed result
- pe_bank_full out 1 pend == NUM_WEIGHT_BANKS-1
- pe_bank_empty out 1 pend == 0
- pe_weight_ovf out 1 sticky: load dropped
- pe_switch_err out 1 sticky: switch with nothing pending

Behaviour:
- Reset (async assert, sync deassert by environment):
  - All registered outputs 0, all banks 0.
  - act_ptr=0, wr_ptr=1, pend=0, so empty=1, full=0.
  - Takes effect immediately, including mid-load or mid-MAC.
- All datapath outputs are registered: 1-cycle latency.
- Disabled (pe_enabled=0):
  - pe_psum_out <= pe_psum_in.
  - All other pass-through outputs <= 0.
  - Banks, pointers, pend and error flags hold; loads and switches are ignored.
- Enabled, pass-through:
  - input_out <= input_in, valid_out <= valid_in, switch_out <= switch_in.
  - weight_out <= weight_in, index_out <= index_in.
  - accept_w_out <= accept_w_in & (index_in != ROW_ID), i.e. a matched load is consumed.
- Load: accept_w_in & index_in==ROW_ID.
  - Accepted if pend < NUM_WEIGHT_BANKS-1, or if a switch is accepted in the same cycle.
  - Accepted: bank[wr_ptr] <= weight_in, wr_ptr advances mod NUM_WEIGHT_BANKS.
  - Otherwise dropped and pe_weight_ovf set.
- Switch: switch_in with pend > 0 → act_ptr advances mod NUM_WEIGHT_BANKS.
  - With pend == 0: act_ptr holds and pe_switch_err is set.
  - A switch never makes a same-cycle load active.
- pend update on simultaneous accepted load and switch: unchanged. Otherwise +1 on accepted load, -1 on accepted switch.
- MAC uses bank[act_ptr] as registered at the start of the cycle; a new weight is first used the cycle after the switch.
  - valid_in=1: psum_out <= psum_in + sext(input_in * active_w), with a 2*DATA_WIDTH_IN-bit signed product.
  - valid_in=0: psum_out <= psum_in.
  - Default arithmetic wraps mod 2^DATA_WIDTH_ACCUM.
- Sticky flags: set has priority over a same-cycle pe_err_clr. Otherwise pe_err_clr clears both flags next edge.
- full/empty are decoded directly from registered pend (no extra latency).

Optional Feature:
- Macro PE_SAT_EN.
- Defined: the accumulation saturates to [-2^(DATA_WIDTH_ACCUM-1), 2^(DATA_WIDTH_ACCUM-1)-1], with overflow detected from the sign of the (DATA_WIDTH_ACCUM+1)-bit sum.
- Undefined: two's-complement wrap; no saturation logic is synthesised.

Test Plan (ROW_ID=5, NUM_WEIGHT_BANKS=3, widths 8/32):
- Reset: drive rst_n=0 mid-MAC → all outputs 0 asynchronously; after release, empty=1, full=0; MAC with input 10, psum 1000 → psum_out 1000.
- Load: index 6, weight 0xAA → weight_out 0xAA, accept_w_out 1, pend 0. Loads at index 5 of 10, 20, 30 → first two accepted, full=1 after the second, third dropped with weight_ovf=1; accept_w_out=0 for all three.
- Switch chain: starting from the load scenario's state (banks 10, 20 pending), step 1 → input 7, psum 100 with valid → psum_out 100 (active weight 0).
- Switch chain step 2 → switch, then the same MAC → 170.
- Switch chain step 3 → switch, then input -2, psum 170 → 130.
- Switch chain step 4 → a third switch with nothing pending sets switch_err=1; input 3, psum 0 → 60. pe_err_clr=1 → both flags 0 next cycle.
- Simultaneous: with pend=2, assert load (index 5) and switch in the same cycle → load accepted, pend stays 2, weight_ovf stays 0.
- Disabled: pe_enabled=0, psum 12345, load at index 5 → psum_out 12345, other outputs 0, pend unchanged.
- Saturation: weight 127, input 127, psum 2147483647 → with PE_SAT_EN psum_out 2147483647; without it psum_out -2147467520.
